// File: rtl/bcd_key_entry_pkg.sv
// Shared types and width helpers for the BCD key-entry front end.
package bcd_key_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int count_width(input int max_digits);
        return $clog2(max_digits + 1);
    endfunction

    function automatic int deb_width(input int deb_cnt);
        return $clog2(deb_cnt + 1);
    endfunction

endpackage

// File: rtl/bcd_key_entry_key_debounce.sv
// Raw active-low key -> 2-FF synchronizer -> stable-count debouncer -> press pulse.
module key_debounce
    import bcd_key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = deb_width(DEBOUNCE_CNT);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the cycle after DEBOUNCE_CNT consecutive mismatches.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CNT)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bcd_key_entry.sv
// Decimal key entry: accumulates debounced BCD digit presses into a binary value.
// Optional macro BCD_KEY_ENTRY_AUTOCOMMIT_EN commits automatically on the digit that fills the entry.
module bcd_key_entry
    import bcd_key_entry_pkg::*;
#(
    parameter int MAX_DIGITS   = 3,
    parameter int OUT_W        = 10,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       digit_in,
    input  logic                             digit_key_n,
    input  logic                             commit_key_n,
    output logic [OUT_W-1:0]                 entry_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
    output logic [OUT_W-1:0]                 value,
    output logic                             value_valid,
    output logic                             err_digit,
    output logic                             err_overflow
);

    localparam int CNT_W = count_width(MAX_DIGITS);

    logic             digit_ev, commit_ev;
    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d, acc_next;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [OUT_W-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             errd_q, errd_d;
    logic             ovf_q, ovf_d;

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_digit_key (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (digit_key_n),
        .press_o (digit_ev)
    );

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_commit_key (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (commit_key_n),
        .press_o (commit_ev)
    );

    assign acc_next = (acc_q << 3) + (acc_q << 1) + {{(OUT_W-4){1'b0}}, digit_in};
    assign cnt_next = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            errd_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            errd_q  <= errd_d;
            ovf_q   <= ovf_d;
        end
    end

    // Commit takes priority; a digit arriving on the same cycle is dropped silently.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        errd_d  = 1'b0;
        ovf_d   = ovf_q;
        if (commit_ev) begin
            if (state_q != EMPTY) begin
                value_d = acc_q;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = EMPTY;
            end
        end else if (digit_ev) begin
            if (digit_in > BCD_MAX) begin
                errd_d = 1'b1;
            end else if (state_q == FULL) begin
                ovf_d = 1'b1;
            end else if (cnt_next == CNT_W'(MAX_DIGITS)) begin
`ifdef BCD_KEY_ENTRY_AUTOCOMMIT_EN
                value_d = acc_next;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = EMPTY;
`else
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                state_d = FULL;
`endif
            end else begin
                acc_d   = acc_next;
                cnt_d   = cnt_next;
                state_d = ENTRY;
            end
        end
    end

    always_comb begin
        entry_value  = acc_q;
        digit_count  = cnt_q;
        value        = value_q;
        value_valid  = valid_q;
        err_digit    = errd_q;
        err_overflow = ovf_q;
    end

endmodule

// File: tb/tb_bcd_key_entry.sv
// Self-checking bench for bcd_key_entry against a digit-queue reference model.
module tb_bcd_key_entry;

    localparam int MAXD = 3;
    localparam int OW   = 10;
    localparam int DB   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    digit_in;
    logic          digit_key_n, commit_key_n;
    logic [OW-1:0] entry_value, value;
    logic [1:0]    digit_count;
    logic          value_valid, err_digit, err_overflow;

    bcd_key_entry #(.MAX_DIGITS(MAXD), .OUT_W(OW), .DEBOUNCE_CNT(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .digit_in     (digit_in),
        .digit_key_n  (digit_key_n),
        .commit_key_n (commit_key_n),
        .entry_value  (entry_value),
        .digit_count  (digit_count),
        .value        (value),
        .value_valid  (value_valid),
        .err_digit    (err_digit),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int valid_seen = 0;
    int errd_seen = 0;

    always @(negedge clk) begin
        if (value_valid === 1'b1) valid_seen++;
        if (err_digit === 1'b1) errd_seen++;
    end

    // Reference model: the entry is simply the list of accepted digits.
    int q[$];
    int exp_value = 0;
    int exp_valid = 0;
    int exp_errd  = 0;
    bit exp_ovf   = 1'b0;

    function automatic int model_entry();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic model_commit();
        if (q.size() > 0) begin
            exp_value = model_entry();
            exp_valid++;
            q.delete();
            exp_ovf = 1'b0;
        end
    endtask

    task automatic model_digit(input int d);
        if (d > 9) begin
            exp_errd++;
        end else if (q.size() == MAXD) begin
            exp_ovf = 1'b1;
        end else begin
            q.push_back(d);
`ifdef BCD_KEY_ENTRY_AUTOCOMMIT_EN
            if (q.size() == MAXD) model_commit();
`endif
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_value = 0;
        exp_ovf   = 1'b0;
    endtask

    // Clean press/release of one or both keys, mirrored into the model.
    task automatic press(input bit dk, input bit ck, input logic [3:0] d);
        @(negedge clk);
        digit_in     = d;
        digit_key_n  = ~dk;
        commit_key_n = ~ck;
        repeat (8) @(negedge clk);
        digit_key_n  = 1'b1;
        commit_key_n = 1'b1;
        repeat (8) @(negedge clk);
        if (ck) model_commit();
        else if (dk) model_digit(int'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; digit_in = 4'd0; digit_key_n = 1'b0; commit_key_n = 1'b0;
        repeat (3) @(negedge clk);
        digit_key_n = 1'b1; commit_key_n = 1'b1;
        do_reset();
        tests++; if (entry_value !== '0) begin fails++; $display("FAIL reset_entry: got %0d want 0", entry_value); end
        tests++; if (digit_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", digit_count); end
        tests++; if (value !== '0) begin fails++; $display("FAIL reset_value: got %0d want 0", value); end
        tests++; if ({value_valid, err_digit, err_overflow} !== 3'b000)
            begin fails++; $display("FAIL reset_flags: got %b want 000", {value_valid, err_digit, err_overflow}); end
        tests++; if (valid_seen != 0) begin fails++; $display("FAIL reset_novalid: got %0d pulses want 0", valid_seen); end
    endtask

    task automatic test_reset_mid();
        int v0 = valid_seen;
        press(1, 0, 4'd5);
        press(1, 0, 4'd2);
        tests++; if (entry_value !== OW'(52)) begin fails++; $display("FAIL mid_entry_pre: got %0d want 52", entry_value); end
        do_reset();
        repeat (4) @(negedge clk);
        tests++; if (entry_value !== '0 || digit_count !== '0)
            begin fails++; $display("FAIL mid_reset: got %0d/%0d want 0/0", entry_value, digit_count); end
        tests++; if (value !== '0) begin fails++; $display("FAIL mid_value: got %0d want 0", value); end
        tests++; if (valid_seen != v0) begin fails++; $display("FAIL mid_novalid: got %0d pulses want 0", valid_seen - v0); end
    endtask

    task automatic test_basic();
        int seq[3] = '{4, 0, 7};
        foreach (seq[i]) begin
            press(1, 0, 4'(seq[i]));
            tests++; if (entry_value !== OW'(model_entry()))
                begin fails++; $display("FAIL basic_entry%0d: got %0d want %0d", i, entry_value, model_entry()); end
        end
        press(0, 1, 4'd0);
        tests++; if (value !== OW'(407)) begin fails++; $display("FAIL basic_value: got %0d want 407", value); end
        tests++; if (valid_seen != exp_valid) begin fails++; $display("FAIL basic_valid: got %0d want %0d", valid_seen, exp_valid); end
        tests++; if (digit_count !== '0) begin fails++; $display("FAIL basic_count: got %0d want 0", digit_count); end
    endtask

    task automatic test_bad_digit();
        press(1, 0, 4'd3);
        press(1, 0, 4'hA);
        tests++; if (errd_seen != exp_errd) begin fails++; $display("FAIL bad_errpulses: got %0d want %0d", errd_seen, exp_errd); end
        tests++; if (entry_value !== OW'(3) || digit_count !== 2'd1)
            begin fails++; $display("FAIL bad_hold: got %0d/%0d want 3/1", entry_value, digit_count); end
        press(0, 1, 4'd0);
    endtask

    task automatic test_overflow();
        repeat (3) press(1, 0, 4'd9);
        tests++; if (value !== OW'(exp_value)) begin fails++; $display("FAIL ovf_value3: got %0d want %0d", value, exp_value); end
        press(1, 0, 4'd4);
        tests++; if (err_overflow !== exp_ovf) begin fails++; $display("FAIL ovf_flag: got %b want %b", err_overflow, exp_ovf); end
        tests++; if (entry_value !== OW'(model_entry()))
            begin fails++; $display("FAIL ovf_entry: got %0d want %0d", entry_value, model_entry()); end
        press(0, 1, 4'd0);
        tests++; if (value !== OW'(exp_value)) begin fails++; $display("FAIL ovf_commit: got %0d want %0d", value, exp_value); end
        tests++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", err_overflow); end
    endtask

    task automatic test_bounce_latency();
        int pat[4] = '{3, 1, 3, 10};
        int first = 0;
        digit_in = 4'd6;
        foreach (pat[i]) begin
            @(negedge clk);
            digit_key_n = (i % 2 == 1) || (i == 3);
            repeat (pat[i] - 1) @(negedge clk);
        end
        tests++; if (digit_count !== '0 || entry_value !== '0)
            begin fails++; $display("FAIL bounce_noevent: got %0d/%0d want 0/0", entry_value, digit_count); end
        @(negedge clk);
        digit_key_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (first == 0 && entry_value === OW'(6)) first = k;
        end
        digit_key_n = 1'b1;
        repeat (10) @(negedge clk);
        model_digit(6);
        // Event fires DB+3 cycles after the fall; registered outputs follow one cycle later.
        tests++; if (first != DB + 4) begin fails++; $display("FAIL latency: got %0d cycles want %0d", first, DB + 4); end
        tests++; if (digit_count !== 2'd1) begin fails++; $display("FAIL single_event: got %0d want 1", digit_count); end
        press(0, 1, 4'd0);
    endtask

    task automatic test_same_cycle();
        int e0 = errd_seen;
        press(1, 0, 4'd1);
        press(1, 0, 4'd2);
        press(1, 1, 4'd5);
        tests++; if (value !== OW'(12)) begin fails++; $display("FAIL same_value: got %0d want 12", value); end
        tests++; if (valid_seen != exp_valid) begin fails++; $display("FAIL same_valid: got %0d want %0d", valid_seen, exp_valid); end
        tests++; if (entry_value !== '0 || digit_count !== '0)
            begin fails++; $display("FAIL same_empty: got %0d/%0d want 0/0", entry_value, digit_count); end
        tests++; if (errd_seen != e0) begin fails++; $display("FAIL same_noerr: got %0d want 0", errd_seen - e0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op = $urandom_range(0, 5);
            logic [3:0] d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            press(op != 4, op >= 4, d);
            tests++; if (entry_value !== OW'(model_entry()))
                begin fails++; $display("FAIL rnd%0d_entry: got %0d want %0d", i, entry_value, model_entry()); end
            tests++; if (digit_count !== 2'(q.size()))
                begin fails++; $display("FAIL rnd%0d_count: got %0d want %0d", i, digit_count, q.size()); end
            tests++; if (value !== OW'(exp_value))
                begin fails++; $display("FAIL rnd%0d_value: got %0d want %0d", i, value, exp_value); end
            tests++; if (err_overflow !== exp_ovf)
                begin fails++; $display("FAIL rnd%0d_ovf: got %b want %b", i, err_overflow, exp_ovf); end
            tests++; if (valid_seen != exp_valid)
                begin fails++; $display("FAIL rnd%0d_valid: got %0d want %0d", i, valid_seen, exp_valid); end
            tests++; if (errd_seen != exp_errd)
                begin fails++; $display("FAIL rnd%0d_errd: got %0d want %0d", i, errd_seen, exp_errd); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_bad_digit();
        test_overflow();
        test_bounce_latency();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_key_entry.md
Name: bcd_key_entry

Overview:
- Decimal-entry front end: the operator sets one BCD digit on the switches and presses a push-button to shift it in.
- The block accumulates the digits into a binary value (acc*10 + digit) and releases that value on a commit press.
- It is the reverse of the binary-to-decimal display path: it turns human decimal input back into a binary count.
- Sits between the raw board KEY/SW pins and any counter or comparator that needs a preset value. It also exports the in-progress value for display.

Parameters:
- MAX_DIGITS, 3, maximum number of decimal digits accepted per entry.
- OUT_W, 10, width of the binary value; must satisfy 2**OUT_W > 10**MAX_DIGITS - 1.
- DEBOUNCE_CNT, 1000000, number of consecutive stable cycles needed before a key level is accepted (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock (50 MHz board clock).
- rst  input  1  synchronous, active-high reset.
- digit_in  input  4  BCD digit from switches; sampled on the cycle the digit event fires.
- digit_key_n  input  1  raw active-low push-button; a press enters digit_in.
- commit_key_n  input  1  raw active-low push-button; a press commits the accumulated value.
- entry_value  output  OUT_W  binary value of the digits entered so far.
- digit_count  output  $clog2(MAX_DIGITS+1)  number of digits currently held.
- value  output  OUT_W  last committed value; held until the next commit.
- value_valid  output  1  one-cycle pulse, aligned with the cycle value updates.
- err_digit  output  1  one-cycle pulse when a digit event sees digit_in > 9.
- err_overflow  output  1  sticky; set when a digit event arrives while full; cleared by commit or rst.

Behaviour:
- Key path, per key:
  - 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CNT consecutive cycles; any reversion restarts the count.
  - Event = one-cycle pulse on the debounced 1->0 transition (press). Releasing a key produces no event.
  - Latency from a clean raw falling edge to the event pulse is DEBOUNCE_CNT+3 cycles.
- Reset:
  - Debounced levels = 1 (released), so no event fires after reset even if a key is held.
  - entry_value=0, digit_count=0, value=0, value_valid=0, err_digit=0, err_overflow=0, state=EMPTY.
  - Reset mid-entry discards the partial entry and emits no value_valid.
- State machine: EMPTY (count 0), ENTRY (0 < count < MAX_DIGITS), FULL (count = MAX_DIGITS).
  - Valid digit event in EMPTY/ENTRY: entry_value <= entry_value*10 + digit_in, computed as (x<<3)+(x<<1)+d at OUT_W bits; count+1. Move to ENTRY, or to FULL when the count reaches MAX_DIGITS. Outputs update on the cycle after the event.
  - Digit event with digit_in > 9, in any state: err_digit pulses; accumulator, count and state are unchanged.
  - Digit event in FULL: ignored; err_overflow <= 1.
  - Commit event in ENTRY/FULL: value <= entry_value and value_valid=1 for one cycle. Same edge: entry_value <= 0, count <= 0, err_overflow <= 0, state EMPTY.
  - Commit event in EMPTY: ignored; no value_valid; value is unchanged.
  - Digit and commit events on the same cycle: commit wins and the digit is dropped (no err pulse).
- Leading zeros count as digits: entering 0,0,5 gives count 3 and value 5.

Optional Feature:
- Macro: BCD_KEY_ENTRY_AUTOCOMMIT_EN.
- Defined: when a valid digit moves the state to FULL, the commit is performed on that same update edge. value <= the new accumulated value, value_valid pulses, and the state returns to EMPTY, so FULL is never resident and err_overflow can never set. A commit key press in EMPTY is still ignored.
- Not defined: behaviour as above; an explicit commit is required.

Decomposition:
- Package bcd_key_entry_pkg holds:
  - the state enum (EMPTY, ENTRY, FULL);
  - constant BCD_MAX = 4'd9;
  - localparam helpers for the count width and the debounce counter width ($clog2(DEBOUNCE_CNT+1)).
- One sub-module, key_debounce: synchronizer + stable counter + press-edge pulse, parameterised by DEBOUNCE_CNT. It is instantiated twice, once per key.

Test Plan (DEBOUNCE_CNT=4 in simulation):
- Digit presses with digit_in 4, 0, 7, then commit -> entry_value steps 4, 40, 407; value=407 (0x197) with one value_valid pulse; digit_count returns to 0.
- Digit press with digit_in=0xA after entering 3 -> err_digit pulses once; entry_value stays 3 and digit_count stays 1.
- Enter 9, 9, 9, then a 4th press -> err_overflow=1 and entry_value stays 999. Commit -> value=999 and err_overflow=0. With BCD_KEY_ENTRY_AUTOCOMMIT_EN: value=999 right after the 3rd digit.
- Raw key bounce (low 3 cycles, high 1, low 3, then high) -> no event; held low for 5+ cycles -> exactly one event, DEBOUNCE_CNT+3 cycles after the last falling edge.
- Enter 5, 2, then pulse rst -> entry_value=0, digit_count=0, value unchanged at 0, no value_valid.
- Digit and commit events forced on the same cycle with 12 entered -> value=12 and value_valid pulses; the digit is not added; the state is EMPTY.
